// File: rtl/lnrv_icb_wrr_arbiter.sv
// lnrv_icb_wrr_arbiter: weighted round-robin grant for a shared ICB command channel.
// Defining LNRV_ICB_ARB_LOCK_EN adds a lock input that pins the grant across quota exhaustion.
module lnrv_icb_wrr_arbiter #(
    parameter int P_ARBT_NUM       = 4,
    parameter int P_WEIGHT_WIDTH   = 4,
    parameter int P_GRANT_ID_WIDTH = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [P_ARBT_NUM-1:0]                request,
    input  logic [P_ARBT_NUM*P_WEIGHT_WIDTH-1:0] cfg_weight,
    input  logic                                 accept,
`ifdef LNRV_ICB_ARB_LOCK_EN
    input  logic                                 lock,
`endif
    output logic [P_ARBT_NUM-1:0]                grant,
    output logic                                 grant_vld,
    output logic [P_GRANT_ID_WIDTH-1:0]          grant_id,
    output logic [P_WEIGHT_WIDTH-1:0]            credit
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t                        state, state_nxt;
    logic [P_GRANT_ID_WIDTH-1:0]   ptr, ptr_nxt, grant_id_nxt, win_id, base;
    logic [P_ARBT_NUM-1:0]         grant_nxt, cand;
    logic [P_WEIGHT_WIDTH-1:0]     credit_nxt, win_field, win_weight;
    logic                          win_vld, lock_q;
    int                            idx;

`ifdef LNRV_ICB_ARB_LOCK_EN
    assign lock_q = lock;
`else
    assign lock_q = 1'b0;
`endif

    assign grant_vld = |grant;

    // Idle searches all requesters after the pointer; busy searches the others after the holder.
    always_comb begin
        cand    = (state == IDLE) ? request : request & ~grant;
        base    = (state == IDLE) ? ptr : grant_id;
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        for (int k = 1; k <= P_ARBT_NUM; k++) begin
            idx = (int'(base) + k) % P_ARBT_NUM;
            if (!win_vld && cand[P_GRANT_ID_WIDTH'(idx)]) begin
                win_vld = 1'b1;
                win_id  = P_GRANT_ID_WIDTH'(idx);
            end
        end
        win_field  = cfg_weight[win_id*P_WEIGHT_WIDTH +: P_WEIGHT_WIDTH];
        win_weight = (win_field == '0) ? P_WEIGHT_WIDTH'(1) : win_field;
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        grant_nxt    = grant;
        grant_id_nxt = grant_id;
        credit_nxt   = credit;
        if (state == IDLE) begin
            if (win_vld) begin
                state_nxt    = BUSY;
                grant_nxt    = P_ARBT_NUM'(1) << win_id;
                grant_id_nxt = win_id;
                credit_nxt   = win_weight;
            end
        end else if (accept && credit > P_WEIGHT_WIDTH'(1)) begin
            credit_nxt = credit - P_WEIGHT_WIDTH'(1);
        end else if ((accept && !lock_q) || (!accept && !request[grant_id])) begin
            ptr_nxt = grant_id;
            if (accept && win_vld) begin
                grant_nxt    = P_ARBT_NUM'(1) << win_id;
                grant_id_nxt = win_id;
                credit_nxt   = win_weight;
            end else begin
                state_nxt    = IDLE;
                grant_nxt    = '0;
                grant_id_nxt = '0;
                credit_nxt   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= P_GRANT_ID_WIDTH'(P_ARBT_NUM - 1);
            grant    <= '0;
            grant_id <= '0;
            credit   <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            grant    <= grant_nxt;
            grant_id <= grant_id_nxt;
            credit   <= credit_nxt;
        end
    end
endmodule

// File: tb/tb_lnrv_icb_wrr_arbiter.sv
// tb_lnrv_icb_wrr_arbiter: directed checks of the weighted round-robin arbiter.
module tb_lnrv_icb_wrr_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  request = 4'b1111;
    logic [15:0] cfg_weight = {4'd1, 4'd3, 4'd2, 4'd1};
    logic        accept = 1'b0;
`ifdef LNRV_ICB_ARB_LOCK_EN
    logic        lock = 1'b0;
`endif
    logic [3:0]  grant;
    logic        grant_vld;
    logic [1:0]  grant_id;
    logic [3:0]  credit;
    int          vectors = 0;
    int          miscompares = 0;
    logic [3:0]  exp_g [7] = '{4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0]  exp_c [7] = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd1, 4'd1};

    lnrv_icb_wrr_arbiter #(.P_ARBT_NUM(4), .P_WEIGHT_WIDTH(4), .P_GRANT_ID_WIDTH(2)) dut (
        .clk(clk), .reset(reset), .request(request), .cfg_weight(cfg_weight), .accept(accept),
`ifdef LNRV_ICB_ARB_LOCK_EN
        .lock(lock),
`endif
        .grant(grant), .grant_vld(grant_vld), .grant_id(grant_id), .credit(credit)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset held with all requesting
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_grant", 32'(grant), 32'h0);
            chk("rst_vld", 32'(grant_vld), 32'h0);
        end
        chk("rst_credit", 32'(credit), 32'h0);
        reset = 1'b0;
        #1;
        chk("rel_grant", 32'(grant), 32'h0);
        tick();
        chk("first_grant", 32'(grant), 32'h1);
        chk("first_credit", 32'(credit), 32'd1);
        chk("first_vld", 32'(grant_vld), 32'h1);
        // weighted rotation m0x1 m1x2 m2x3 m3x1 m0
        accept = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("wrr_grant", 32'(grant), 32'(exp_g[i]));
            chk("wrr_credit", 32'(credit), 32'(exp_c[i]));
        end
        chk("wrr_id", 32'(grant_id), 32'd0);
        // single requester m2 with weight 0
        request = 4'b0100;
        cfg_weight[11:8] = 4'd0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("w0_grant", 32'(grant), 32'h4);
            chk("w0_credit", 32'(credit), 32'd1);
            tick();
            chk("w0_idle", 32'(grant), 32'h0);
            chk("w0_idle_vld", 32'(grant_vld), 32'h0);
        end
        // m1 with credit 3 stalls, then drops its request
        accept = 1'b0;
        cfg_weight[7:4] = 4'd3;
        request = 4'b0110;
        tick();
        chk("stall_grant", 32'(grant), 32'h2);
        chk("stall_credit", 32'(credit), 32'd3);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_hold", 32'(grant), 32'h2);
        end
        chk("stall_credit_hold", 32'(credit), 32'd3);
        request = 4'b0100;
        tick();
        chk("drop_grant", 32'(grant), 32'h0);
        tick();
        chk("drop_next", 32'(grant), 32'h4);
        chk("drop_next_id", 32'(grant_id), 32'd2);
        // zero-bubble switch to m3 with credit 2, then async reset
        cfg_weight[15:12] = 4'd2;
        request = 4'b1000;
        accept = 1'b1;
        tick();
        chk("m3_grant", 32'(grant), 32'h8);
        chk("m3_credit", 32'(credit), 32'd2);
        chk("m3_id", 32'(grant_id), 32'd3);
        #1 reset = 1'b1;
        #1;
        chk("async_grant", 32'(grant), 32'h0);
        chk("async_credit", 32'(credit), 32'h0);
        chk("async_id", 32'(grant_id), 32'h0);
        chk("async_vld", 32'(grant_vld), 32'h0);
        tick();
        reset = 1'b0;
        request = 4'b1111;
        accept = 1'b0;
        tick();
        chk("post_rst_grant", 32'(grant), 32'h1);
        chk("post_rst_credit", 32'(credit), 32'd1);
`ifdef LNRV_ICB_ARB_LOCK_EN
        // locked m0 survives exhausting accepts
        request = 4'b0011;
        lock = 1'b1;
        accept = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("lock_hold", 32'(grant), 32'h1);
            chk("lock_credit", 32'(credit), 32'd1);
        end
        lock = 1'b0;
        tick();
        chk("unlock_grant", 32'(grant), 32'h2);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
